// File: rtl/deserializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer_pkg
//  Description : Shared defaults and counter types for the serial-link
//                receive path (deserializer and its timing wrapper).
//  Revision    : 1.0 - initial release
// ============================================================================
package deserializer_pkg;

    // Default width of the assembled parallel word (power of two, >= 4).
    localparam int c_DATA_W      = 16;
    // Width of the valid-bit count that travels with each word.
    localparam int c_MOD_W       = $clog2(c_DATA_W);
    // Default idle-gap length that triggers a partial-word flush.
    localparam int c_IDLE_CYCLES = 8;
    // The idle counter must hold values up to IDLE_CYCLES.
    localparam int c_IDLE_W      = $clog2(c_IDLE_CYCLES + 1);

    typedef logic [c_MOD_W-1:0]  bit_cnt_t;
    typedef logic [c_IDLE_W-1:0] idle_cnt_t;

endpackage : deserializer_pkg
`default_nettype wire

// File: rtl/deserializer_wrap.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer_wrap
//  Description : Timing wrapper for fmax runs: registers every input and
//                output of the deserializer so the core sits between flops.
//                Honours DESERIALIZER_IDLE_FLUSH_EN through the core.
//  Ports       : same names and meanings as deserializer; every path has
//                one extra register stage on input and on output.
//  Revision    : 1.0 - initial release
// ============================================================================
module deserializer_wrap
    import deserializer_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int IDLE_CYCLES = c_IDLE_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      data_i,
    input  logic                      data_val_i,
    output logic [DATA_W-1:0]         deser_data_o,
    output logic [$clog2(DATA_W)-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o
);

    localparam int c_CNT_W = $clog2(DATA_W);

    logic               r_srst_q;
    logic               r_data_in_q;
    logic               r_val_in_q;
    logic [DATA_W-1:0]  w_core_data;
    logic [c_CNT_W-1:0] w_core_mod;
    logic               w_core_val;
    logic               w_core_busy;
    logic [DATA_W-1:0]  r_data_out_q;
    logic [c_CNT_W-1:0] r_mod_out_q;
    logic               r_val_out_q;
    logic               r_busy_out_q;

    always_ff @(posedge clk_i) begin
        r_srst_q <= srst_i;
        if (srst_i) begin
            r_data_in_q  <= 1'b0;
            r_val_in_q   <= 1'b0;
            r_data_out_q <= '0;
            r_mod_out_q  <= '0;
            r_val_out_q  <= 1'b0;
            r_busy_out_q <= 1'b0;
        end else begin
            r_data_in_q  <= data_i;
            r_val_in_q   <= data_val_i;
            r_data_out_q <= w_core_data;
            r_mod_out_q  <= w_core_mod;
            r_val_out_q  <= w_core_val;
            r_busy_out_q <= w_core_busy;
        end
    end

    deserializer #(
        .DATA_W      (DATA_W),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_core (
        .clk_i            (clk_i),
        .srst_i           (r_srst_q),
        .data_i           (r_data_in_q),
        .data_val_i       (r_val_in_q),
        .deser_data_o     (w_core_data),
        .deser_data_mod_o (w_core_mod),
        .deser_data_val_o (w_core_val),
        .busy_o           (w_core_busy)
    );

    assign deser_data_o     = r_data_out_q;
    assign deser_data_mod_o = r_mod_out_q;
    assign deser_data_val_o = r_val_out_q;
    assign busy_o           = r_busy_out_q;

endmodule : deserializer_wrap
`default_nettype wire

// File: rtl/deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : deserializer
//  Description : Serial-to-parallel receiver. Collects one bit per cycle
//                (qualified by data_val_i), MSB first, and emits each full
//                DATA_W-bit word with a one-cycle valid pulse.
//                Optional macro DESERIALIZER_IDLE_FLUSH_EN: a partial word
//                idle for IDLE_CYCLES cycles is flushed left-aligned with
//                its bit count on deser_data_mod_o.
//  Ports       : clk_i            - clock, rising edge
//                srst_i           - synchronous reset, active-high
//                data_i           - serial data bit
//                data_val_i       - qualifies data_i
//                deser_data_o     - assembled word, first bit in MSB
//                deser_data_mod_o - valid-bit count, 0 = all bits valid
//                deser_data_val_o - one-cycle word-valid pulse
//                busy_o           - a partial word is held
//  Revision    : 1.0 - initial release
// ============================================================================
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int IDLE_CYCLES = c_IDLE_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      data_i,
    input  logic                      data_val_i,
    output logic [DATA_W-1:0]         deser_data_o,
    output logic [$clog2(DATA_W)-1:0] deser_data_mod_o,
    output logic                      deser_data_val_o,
    output logic                      busy_o
);

    localparam int                 c_CNT_W    = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // The bit counter doubles as the state: zero is IDLE, non-zero is ACC.
    logic [DATA_W-1:0]  r_shreg_q, w_shreg_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic               r_busy_q,  w_busy_d;
    logic [DATA_W-1:0]  r_data_q,  w_data_d;
    logic               r_val_q,   w_val_d;
    logic [DATA_W-1:0]  w_shift;

    // Word as it would look after shifting in the current bit.
    assign w_shift = {r_shreg_q[DATA_W-2:0], data_i};

`ifdef DESERIALIZER_IDLE_FLUSH_EN
    localparam int                 c_IDL_W     = $clog2(IDLE_CYCLES + 1);
    localparam logic [c_IDL_W-1:0] c_IDLE_LAST = c_IDL_W'(IDLE_CYCLES - 1);
    localparam logic [c_IDL_W-1:0] c_IDLE_ONE  = c_IDL_W'(1);
    localparam int                 c_SH_W      = c_CNT_W + 1;
    localparam logic [c_SH_W-1:0]  c_SH_FULL   = c_SH_W'(DATA_W);

    logic [c_IDL_W-1:0] r_idle_q, w_idle_d;
    logic [c_CNT_W-1:0] r_mod_q,  w_mod_d;
    logic [c_SH_W-1:0]  w_align_sh;
    logic [DATA_W-1:0]  w_flush_word;

    // The k held bits sit in the low end of the shift register; shifting by
    // DATA_W-k moves the first of them to the MSB, discards stale upper bits
    // from earlier words and zero-fills the bottom.
    assign w_align_sh   = c_SH_FULL - {1'b0, r_cnt_q};
    assign w_flush_word = r_shreg_q << w_align_sh;
`else
    // IDLE_CYCLES only matters when the flush logic is built in.
    logic w_cfg_unused;
    assign w_cfg_unused = (IDLE_CYCLES != 0);
`endif

    always_comb begin
        w_shreg_d = r_shreg_q;
        w_cnt_d   = r_cnt_q;
        w_busy_d  = r_busy_q;
        w_data_d  = r_data_q;
        w_val_d   = 1'b0;
`ifdef DESERIALIZER_IDLE_FLUSH_EN
        w_idle_d  = r_idle_q;
        w_mod_d   = r_mod_q;
`endif
        if (data_val_i) begin
            w_shreg_d = w_shift;
`ifdef DESERIALIZER_IDLE_FLUSH_EN
            w_idle_d  = '0;
`endif
            if (r_cnt_q == c_CNT_LAST) begin
                // Last bit of the word: publish it and return to IDLE.
                w_cnt_d  = '0;
                w_busy_d = 1'b0;
                w_data_d = w_shift;
                w_val_d  = 1'b1;
`ifdef DESERIALIZER_IDLE_FLUSH_EN
                w_mod_d  = '0;
`endif
            end else begin
                w_cnt_d  = r_cnt_q + c_CNT_ONE;
                w_busy_d = 1'b1;
            end
        end
`ifdef DESERIALIZER_IDLE_FLUSH_EN
        else if (r_cnt_q != '0) begin
            if (r_idle_q == c_IDLE_LAST) begin
                // Gap reached IDLE_CYCLES: flush the partial word.
                w_data_d = w_flush_word;
                w_mod_d  = r_cnt_q;
                w_val_d  = 1'b1;
                w_cnt_d  = '0;
                w_busy_d = 1'b0;
                w_idle_d = '0;
            end else begin
                w_idle_d = r_idle_q + c_IDLE_ONE;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_shreg_q <= '0;
            r_cnt_q   <= '0;
            r_busy_q  <= 1'b0;
            r_data_q  <= '0;
            r_val_q   <= 1'b0;
`ifdef DESERIALIZER_IDLE_FLUSH_EN
            r_idle_q  <= '0;
            r_mod_q   <= '0;
`endif
        end else begin
            r_shreg_q <= w_shreg_d;
            r_cnt_q   <= w_cnt_d;
            r_busy_q  <= w_busy_d;
            r_data_q  <= w_data_d;
            r_val_q   <= w_val_d;
`ifdef DESERIALIZER_IDLE_FLUSH_EN
            r_idle_q  <= w_idle_d;
            r_mod_q   <= w_mod_d;
`endif
        end
    end

    assign deser_data_o     = r_data_q;
    assign deser_data_val_o = r_val_q;
    assign busy_o           = r_busy_q;
`ifdef DESERIALIZER_IDLE_FLUSH_EN
    assign deser_data_mod_o = r_mod_q;
`else
    // Without flushing every emitted word is complete.
    assign deser_data_mod_o = '0;
`endif

endmodule : deserializer
`default_nettype wire

// File: tb/tb_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_deserializer
//  Description : Self-checking bench for deserializer (DATA_W=16,
//                IDLE_CYCLES=8). Flush sequences are compiled only when
//                DESERIALIZER_IDLE_FLUSH_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_deserializer;
    import deserializer_pkg::*;

    localparam int c_W    = 16;
    localparam int c_IDLE = 8;

    logic            clk = 1'b0;
    logic            srst_i;
    logic            data_i;
    logic            data_val_i;
    logic [c_W-1:0]  deser_data_o;
    bit_cnt_t        deser_data_mod_o;
    logic            deser_data_val_o;
    logic            busy_o;

    always #5 clk = ~clk;

    deserializer #(
        .DATA_W      (c_W),
        .IDLE_CYCLES (c_IDLE)
    ) dut (
        .clk_i            (clk),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        string          name;
        logic [c_W-1:0] word;
        int             max_gap;
        logic [c_W-1:0] exp_data;
        bit_cnt_t       exp_mod;
    } vec_t;

    typedef struct {
        logic [c_W-1:0] data;
        bit_cnt_t       mod;
        int unsigned    cyc;
    } pulse_t;

    pulse_t      pq[$];
    int unsigned cyc = 0;
    logic        prev_val = 1'b0;
    int          n_b2b = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every output pulse and flag consecutive-cycle pulses.
    always @(negedge clk) begin
        pulse_t p;
        if (deser_data_val_o === 1'b1) begin
            p.data = deser_data_o;
            p.mod  = deser_data_mod_o;
            p.cyc  = cyc;
            pq.push_back(p);
            if (prev_val === 1'b1) n_b2b++;
        end
        prev_val = deser_data_val_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_bit(input logic b);
        data_i     = b;
        data_val_i = 1'b1;
        @(posedge clk);
        #1;
        data_val_i = 1'b0;
    endtask

    task automatic idle(input int n);
        data_val_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [c_W-1:0] w, input int max_gap);
        for (int i = c_W - 1; i >= 0; i--) begin
            send_bit(w[i]);
            if (max_gap > 0 && i > 0) idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    vec_t vecs[6];

    initial begin
        logic [c_W-1:0] w;
        logic [6:0]     part;
        logic [4:0]     head;
        logic [10:0]    tail;

        vecs[0] = '{"zeros",     16'h0000, 0, 16'h0000, 4'd0};
        vecs[1] = '{"ones",      16'hFFFF, 0, 16'hFFFF, 4'd0};
        vecs[2] = '{"ends",      16'h8001, 2, 16'h8001, 4'd0};
        vecs[3] = '{"gap_1234",  16'h1234, 5, 16'h1234, 4'd0};
        vecs[4] = '{"inner",     16'h7FFE, 1, 16'h7FFE, 4'd0};
        vecs[5] = '{"alt_5aa5",  16'h5AA5, 3, 16'h5AA5, 4'd0};

        srst_i = 1'b1; data_i = 1'b0; data_val_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        srst_i = 1'b0;
        check("rst_data", 32'(deser_data_o), 32'h0);
        check("rst_mod",  32'(deser_data_mod_o), 32'h0);
        check("rst_val",  32'(deser_data_val_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);

        // 0xA5C3 back-to-back with per-bit busy/valid timing.
        w = 16'hA5C3;
        for (int k = 1; k <= c_W; k++) begin
            send_bit(w[c_W - k]);
            check($sformatf("a5c3_busy_%0d", k), 32'(busy_o), (k < c_W) ? 32'h1 : 32'h0);
            check($sformatf("a5c3_val_%0d", k), 32'(deser_data_val_o), (k == c_W) ? 32'h1 : 32'h0);
        end
        check("a5c3_data", 32'(deser_data_o), 32'hA5C3);
        check("a5c3_mod",  32'(deser_data_mod_o), 32'h0);
        idle(1);
        check("a5c3_val_drop", 32'(deser_data_val_o), 32'h0);
        check("a5c3_hold",     32'(deser_data_o), 32'hA5C3);

        // Two contiguous words: pulses exactly one word apart.
        pq.delete();
        send_word(16'hFFFF, 0);
        send_word(16'h0001, 0);
        idle(2);
        check("b2b_count", 32'(pq.size()), 32'd2);
        if (pq.size() == 2) begin
            check("b2b_data0", 32'(pq[0].data), 32'hFFFF);
            check("b2b_data1", 32'(pq[1].data), 32'h0001);
            check("b2b_spacing", pq[1].cyc - pq[0].cyc, 32'd16);
        end

        // Table-driven words, some with random gaps between bits.
        foreach (vecs[i]) begin
            pq.delete();
            send_word(vecs[i].word, vecs[i].max_gap);
            idle(2);
            check({vecs[i].name, "_count"}, 32'(pq.size()), 32'd1);
            if (pq.size() >= 1) begin
                check({vecs[i].name, "_data"}, 32'(pq[0].data), 32'(vecs[i].exp_data));
                check({vecs[i].name, "_mod"},  32'(pq[0].mod),  32'(vecs[i].exp_mod));
            end
        end

        // Partial word discarded by reset; reset overrides a valid bit.
        pq.delete();
        part = 7'b0101101;
        for (int i = 6; i >= 0; i--) send_bit(part[i]);
        check("part_busy", 32'(busy_o), 32'h1);
        srst_i = 1'b1; data_val_i = 1'b1; data_i = 1'b1;
        @(posedge clk);
        #1;
        srst_i = 1'b0; data_val_i = 1'b0;
        check("srst_data", 32'(deser_data_o), 32'h0);
        check("srst_mod",  32'(deser_data_mod_o), 32'h0);
        check("srst_val",  32'(deser_data_val_o), 32'h0);
        check("srst_busy", 32'(busy_o), 32'h0);
        send_word(16'hBEEF, 0);
        idle(2);
        check("beef_count", 32'(pq.size()), 32'd1);
        if (pq.size() >= 1) check("beef_data", 32'(pq[0].data), 32'hBEEF);

`ifdef DESERIALIZER_IDLE_FLUSH_EN
        // Five bits then a gap of IDLE_CYCLES: left-aligned flush with mod=5.
        pq.delete();
        head = 5'b10110;
        for (int i = 4; i >= 0; i--) send_bit(head[i]);
        idle(c_IDLE - 1);
        check("flush_early_val", 32'(pq.size()), 32'd0);
        check("flush_early_busy", 32'(busy_o), 32'h1);
        idle(1);
        check("flush_val",  32'(deser_data_val_o), 32'h1);
        check("flush_data", 32'(deser_data_o), 32'hB000);
        check("flush_mod",  32'(deser_data_mod_o), 32'd5);
        check("flush_busy", 32'(busy_o), 32'h0);
        idle(2);
        check("flush_count", 32'(pq.size()), 32'd1);

        // A gap one short of the limit must not flush.
        pq.delete();
        tail = 11'h7FF;
        for (int i = 4; i >= 0; i--) send_bit(head[i]);
        idle(c_IDLE - 1);
        for (int i = 10; i >= 0; i--) send_bit(tail[i]);
        idle(2);
        check("noflush_count", 32'(pq.size()), 32'd1);
        if (pq.size() >= 1) begin
            check("noflush_data", 32'(pq[0].data), 32'hB7FF);
            check("noflush_mod",  32'(pq[0].mod),  32'd0);
        end
`endif

        check("no_back_to_back_pulses", 32'(n_b2b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_deserializer
`default_nettype wire
